// File: rtl/clk_up.sv
// clk_up: slow-to-fast clock-domain receiver.
//
// The slow source clock is treated as an asynchronous data input on the fast
// clock. It passes through a SYNC_STAGES-deep synchronizer, and its falling
// edge is detected from the synchronized copy. Each falling edge samples
// slow_data, which was launched on the slow rising edge. By then the word has
// been stable for half a slow period. Captured words go into a 2-entry
// valid/ready buffer read by fast-domain consumers.
//
// Optional feature: define CLK_UP_WORD_COUNT_EN to add the word_count[15:0]
// output. It is a wrapping count of accepted captures.
//
// Timing assumption (not checked in hardware): the slow high and low phases
// each last at least SYNC_STAGES+2 fast periods. SYNC_STAGES must be 2..4.

module clk_up #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic [WIDTH-1:0] slow_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic             overflow
`ifdef CLK_UP_WORD_COUNT_EN
    ,
    output logic [15:0]      word_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // ------------------------------------------------------------------
    // Synchronizer and falling-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   fall;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign fall     = prev_q & ~sync_out;

    // Shift slow_clk through the synchronizer and keep one cycle of history.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prev_q <= sync_out;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry buffer: head_q is always the oldest word, tail_q the second
    // ------------------------------------------------------------------
    buf_state_t       state_q;
    buf_state_t       state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    logic pop;
    logic load_head;
    logic head_from_tail;
    logic load_tail;
    logic drop;
    logic accept;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign pop       = out_valid & out_ready;

    // Buffer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control for the capture/pop combinations.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        drop           = 1'b0;
        accept         = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (fall) begin
                    load_head = 1'b1;
                    accept    = 1'b1;
                    state_d   = ONE;
                end
            end

            ONE: begin
                if (fall && pop) begin
                    // Old head leaves as the new word arrives at the head.
                    load_head = 1'b1;
                    accept    = 1'b1;
                end else if (fall) begin
                    load_tail = 1'b1;
                    accept    = 1'b1;
                    state_d   = FULL;
                end else if (pop) begin
                    // head_q is left as-is: out_data holds its last value.
                    state_d   = EMPTY;
                end
            end

            FULL: begin
                if (fall && pop) begin
                    // Head advances and the freed slot takes the new word.
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                    load_tail      = 1'b1;
                    accept         = 1'b1;
                end else if (fall) begin
                    drop = 1'b1;
                end else if (pop) begin
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                    state_d        = ONE;
                end
            end

            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Buffer storage: head and tail words.
    // NOTE: both data words are reset because out_data must read 0 out of
    // reset. The tail has no such requirement, but resetting it costs nothing
    // at two entries and keeps it free of X in simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head) begin
                head_q <= head_from_tail ? tail_q : slow_data;
            end
            if (load_tail) begin
                tail_q <= slow_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow: a drop wins over a same-edge clear
    // ------------------------------------------------------------------
    // Set overflow on a dropped capture; otherwise clear it on request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Optional accepted-word counter
    // ------------------------------------------------------------------
`ifdef CLK_UP_WORD_COUNT_EN
    // Count accepted captures (dropped words excluded), wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= 16'd0;
        end else if (accept) begin
            word_count <= word_count + 16'd1;
        end
    end
`else
    // Without the counter, accept has no consumer.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_clk_up.sv
// tb_clk_up: scoreboard bench for clk_up.
// The stimulus pushes each word the consumer should eventually see into a
// queue. A monitor on the falling clock edge pops and compares on every
// handshake. Directed point checks cover reset values, latency, overflow and
// the reset-in-flight case.

module tb_clk_up;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             slow_clk;
    logic [WIDTH-1:0] slow_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             ovf_clr;
    logic             overflow;
`ifdef CLK_UP_WORD_COUNT_EN
    logic [15:0]      word_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_q[$];

    clk_up #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .slow_data (slow_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
`ifdef CLK_UP_WORD_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then move 1 ns past the edge to drive inputs.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full slow period carrying word d. Five fast cycles are high and
    // five are low. The capture edge is the third fast edge of the low phase.
    task automatic slow_word(input logic [WIDTH-1:0] d, input int half = 5);
        slow_clk  = 1'b1;
        slow_data = d;
        step(half);
        slow_clk = 1'b0;
        step(half);
    endtask

    // Slow period that drives out_ready (and ovf_clr) high only for the capture edge.
    task automatic slow_word_pulse(input logic [WIDTH-1:0] d, input logic rdy,
                                   input logic clr);
        slow_clk  = 1'b1;
        slow_data = d;
        step(5);
        slow_clk = 1'b0;
        step(2);
        out_ready = rdy;
        ovf_clr   = clr;
        step(1);
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        step(2);
    endtask

    // Scoreboard monitor: compare each handshaked word against the queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %h, expected no word", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
`ifdef CLK_UP_WORD_COUNT_EN
        #20_000_000;
`else
        #2_000_000;
`endif
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        reset     = 1'b1;
        slow_clk  = 1'b0;
        slow_data = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        step(3);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        step(2);

        // Single word: latency 3 edges, 1-cycle valid pulse.
        out_ready = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        slow_clk  = 1'b1;
        slow_data = 32'hDEADBEEF;
        step(5);
        slow_clk = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", lat, 32'd3);
        @(posedge clk);
        @(negedge clk);
        check("pulse_width", {31'd0, out_valid}, 32'd0);
        step(3);

        // Buffer fill: third word dropped.
        out_ready = 1'b0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        slow_word(32'd1);
        slow_word(32'd2);
        check("fill_no_ovf", {31'd0, overflow}, 32'd0);
        slow_word(32'd3);
        check("fill_ovf", {31'd0, overflow}, 32'd1);
        check("fill_valid", {31'd0, out_valid}, 32'd1);
        check("fill_head", out_data, 32'd1);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        step(1);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("empty_hold", out_data, 32'd2);

        // Clear the sticky flag left by the fill test.
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // FULL with capture and pop on the same edge.
        exp_q.push_back(32'hA);
        exp_q.push_back(32'hB);
        exp_q.push_back(32'hC);
        slow_word(32'hA);
        slow_word(32'hB);
        slow_word_pulse(32'hC, 1'b1, 1'b0);
        check("cap_pop_ovf", {31'd0, overflow}, 32'd0);
        check("cap_pop_head", out_data, 32'hB);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        step(1);
        check("cap_pop_empty", {31'd0, out_valid}, 32'd0);

        // Drop coinciding with ovf_clr: the set wins.
        exp_q.push_back(32'hD);
        exp_q.push_back(32'hE);
        slow_word(32'hD);
        slow_word(32'hE);
        slow_word_pulse(32'hF, 1'b0, 1'b1);
        check("ovf_priority", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clear_later", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        step(1);

        // Reset while ONE, with a fall in the synchronizer.
        slow_word(32'h1111_1111);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        slow_clk  = 1'b1;
        slow_data = 32'h2222_2222;
        step(5);
        slow_clk = 1'b0;
        step(1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async_data", out_data, 32'd0);
        step(3);
        reset = 1'b0;
        step(10);
        check("no_spurious", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        exp_q.push_back(32'h3333_3333);
        slow_word(32'h3333_3333);
        out_ready = 1'b0;
        check("post_rst_empty", {31'd0, out_valid}, 32'd0);

`ifdef CLK_UP_WORD_COUNT_EN
        // Five captures with one dropped give a count of 4.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        check("wc_reset", {16'd0, word_count}, 32'd0);
        exp_q.push_back(32'h51);
        exp_q.push_back(32'h52);
        slow_word(32'h51);
        slow_word(32'h52);
        slow_word(32'h53);
        out_ready = 1'b1;
        exp_q.push_back(32'h54);
        exp_q.push_back(32'h55);
        step(3);
        slow_word(32'h54);
        slow_word(32'h55);
        check("wc_four", {16'd0, word_count}, 32'd4);

        // 65535 accepted captures leave 16'hFFFF; one more wraps to 0.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        for (int i = 0; i < 65535; i++) begin
            exp_q.push_back(i[WIDTH-1:0]);
            slow_word(i[WIDTH-1:0], 4);
        end
        check("wc_ffff", {16'd0, word_count}, 32'h0000FFFF);
        exp_q.push_back(32'hCAFE);
        slow_word(32'hCAFE, 4);
        check("wc_wrap", {16'd0, word_count}, 32'd0);
        out_ready = 1'b0;
`endif

        step(2);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
